// File: rtl/shift_ctrl_if.sv
// shift_ctrl_if -- request/response bundle for the multi-cycle shifter.
//   start   : request to begin an operation (accepted only while idle)
//   op      : 00 SLL, 01 SRA, 10 SRL, 11 ROR
//   shamt   : shift amount 0..31
//   data_in : operand
//   result  : working register, valid when done pulses, held while idle
//   busy    : operation in progress (SHIFT and DONE states)
//   done    : one-cycle pulse marking result valid
// master = requester side, slave = shifter side.
interface shift_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (
    output start, op, shamt, data_in,
    input  result, busy, done
  );

  modport slave (
    input  start, op, shamt, data_in,
    output result, busy, done
  );
endinterface

// File: rtl/shift_ctrl.sv
// shift_ctrl -- iterative 32-bit shifter, one bit position per clock.
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts any operation (no done pulse)
//   sif   : shift_ctrl_if.slave (start/op/shamt/data_in in,
//           result/busy/done out)
// A start seen in IDLE captures operand, amount and op. SHIFT then applies
// one 1-bit shift per cycle until the down-counter reaches zero, spends one
// more cycle to notice the zero, and moves to DONE for a single cycle.
// Latency start->done is therefore shamt+2 cycles; busy covers every cycle
// from the one after acceptance through DONE. start is only looked at in
// IDLE, so a held start is re-accepted on the first IDLE cycle after DONE.
module shift_ctrl (
  input  logic         clock,
  input  logic         reset,
  shift_ctrl_if.slave  sif
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic        busy_q;
  logic        done_q;

  // Single-position step for the captured op.
  function automatic logic [31:0] step1(input logic [31:0] v,
                                        input logic [1:0]  o);
    logic [31:0] r;
    r = v;
    case (o)
      OP_SLL:  r = {v[30:0], 1'b0};
      OP_SRA:  r = {v[31], v[31:1]};
      OP_SRL:  r = {1'b0, v[31:1]};
      OP_ROR:  r = {v[0], v[31:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      op_q   <= OP_SLL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (sif.start) begin
            work   <= sif.data_in;
            cnt    <= sif.shamt;
            op_q   <= sif.op;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Counter is checked before decrementing, so it can never wrap.
          if (cnt != 5'd0) begin
            work <= step1(work, op_q);
            cnt  <= cnt - 5'd1;
          end else begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; IDLE picks it up next cycle.
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign sif.result = work;
  assign sif.busy   = busy_q;
  assign sif.done   = done_q;

endmodule

// File: tb/tb_shift_ctrl.sv
module tb_shift_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  shift_ctrl_if sif();

  shift_ctrl dut (
    .clock (clock),
    .reset (reset),
    .sif   (sif.slave)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference built from whole-word operators, independent of bit stepping.
  function automatic logic [31:0] ref_shift(input logic [1:0] o,
                                            input logic [31:0] d,
                                            input logic [4:0] s);
    int sh;
    sh = int'(s);
    case (o)
      2'b00:   return d << sh;
      2'b01:   return $unsigned($signed(d) >>> sh);
      2'b10:   return d >> sh;
      default: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
    endcase
  endfunction

  // Called #1 after an edge in an idle cycle N; returns #1 into cycle N+1.
  task automatic issue(input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s);
    exp_t e;
    sif.start   = 1'b1;
    sif.op      = o;
    sif.shamt   = s;
    sif.data_in = d;
    e.res = ref_shift(o, d, s);
    e.lat = int'(s) + 2;
    sbq.push_back(e);
    @(posedge clock); #1;
    sif.start = 1'b0;
  endtask

  // Called in cycle N+1. Checks busy every cycle, done latency and result,
  // then the following idle cycle (no second done, busy low, result held).
  // junk>0 drives a conflicting start with other operands for that many
  // cycles after acceptance.
  task automatic wait_done(input string name, input int junk);
    exp_t e;
    bit   seen;
    e = sbq.pop_front();
    seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c <= junk) begin
        sif.start   = 1'b1;
        sif.data_in = 32'hFFFF_0000;
        sif.op      = 2'b11;
        sif.shamt   = 5'd3;
      end else if (junk > 0) begin
        sif.start = 1'b0;
      end
      @(negedge clock);
      n_cmp++;
      if (sif.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy cyc N+%0d: got %b want 1", name, c, sif.busy);
      end
      if (sif.done === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (c !== e.lat) begin
          n_bad++;
          $display("FAIL %s latency: got %0d want %0d", name, c, e.lat);
        end
        n_cmp++;
        if (sif.result !== e.res) begin
          n_bad++;
          $display("FAIL %s result: got %h want %h", name, sif.result, e.res);
        end
      end
      @(posedge clock); #1;
      if (seen) break;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s timeout: got no done want done", name);
    end
    @(negedge clock);
    n_cmp++;
    if (sif.done !== 1'b0 || sif.busy !== 1'b0 || sif.result !== e.res) begin
      n_bad++;
      $display("FAIL %s idle after: got done=%b busy=%b res=%h want 0 0 %h",
               name, sif.done, sif.busy, sif.result, e.res);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_cmp++;
    if (sif.result !== 32'h0 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got res=%h busy=%b done=%b want 0 0 0",
               sif.result, sif.busy, sif.done);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_sra();
    issue(2'b01, 32'h8000_0000, 5'd4);
    wait_done("sra4", 0);
  endtask

  task automatic test_sll31();
    issue(2'b00, 32'h0000_0001, 5'd31);
    wait_done("sll31", 0);
  endtask

  task automatic test_shamt0();
    issue(2'b10, 32'hDEAD_BEEF, 5'd0);
    wait_done("srl0", 0);
  endtask

  task automatic test_ror_srl();
    issue(2'b11, 32'h0000_000F, 5'd4);
    wait_done("ror4", 0);
    issue(2'b10, 32'h8000_0000, 5'd4);
    wait_done("srl4", 0);
  endtask

  task automatic test_ignore_start();
    issue(2'b00, 32'h0000_0001, 5'd8);
    wait_done("ignore_start", 3);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sif.start   = 1'b1;
    sif.op      = 2'b00;
    sif.shamt   = 5'd2;
    sif.data_in = 32'h0000_0003;
    e.res = 32'h0000_000C; e.lat = 4;
    sbq.push_back(e);
    @(posedge clock); #1;
    sif.data_in = 32'h0000_0005;   // start stays high throughout
    wait_done("b2b_first", 0);
    e.res = 32'h0000_0014; e.lat = 4;
    sbq.push_back(e);
    @(posedge clock); #1;
    sif.start = 1'b0;
    wait_done("b2b_second", 0);
  endtask

  task automatic test_reset_mid();
    issue(2'b01, 32'h8000_0000, 5'd20);
    sbq.delete();                  // this one is aborted
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (sif.result !== 32'h0 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got res=%h busy=%b done=%b want 0 0 0",
               sif.result, sif.busy, sif.done);
    end
    @(posedge clock); #1;
    issue(2'b01, 32'h8000_0000, 5'd20);
    wait_done("after_reset", 0);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] d;
    logic [4:0]  s;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      issue(o, d, s);
      wait_done("random", 0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset       = 1'b1;
    sif.start   = 1'b0;
    sif.op      = 2'b00;
    sif.shamt   = 5'd0;
    sif.data_in = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_sra();
    test_sll31();
    test_shamt0();
    test_ror_srl();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The block SHALL have the port `clock`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, synchronous, active-high.
REQ-003 The block SHALL have the port `start`: input, 1 bit, request to begin a shift operation.
REQ-004 The block SHALL have the port `op`: input, 2 bits, operation select: 00 SLL, 01 SRA, 10 SRL, 11 ROR (rotate right).
REQ-005 The block SHALL have the port `shamt`: input, 5 bits, shift amount 0-31.
REQ-006 The block SHALL have the port `data_in`: input, 32 bits, operand.
REQ-007 The block SHALL have the port `result`: output, 32 bits, shifted value.
REQ-008 The block SHALL have the port `busy`: output, 1 bit, high while an operation is in progress (states LOAD-less SHIFT and DONE).
REQ-009 The block SHALL have the port `done`: output, 1 bit, one-cycle pulse marking `result` valid.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 In IDLE with start=1, the block SHALL capture data_in into the working register, shamt into a 5-bit down-counter, and op into an op register, then go to SHIFT; busy=0, done=0 in IDLE.
REQ-012 `start` SHALL be ignored in SHIFT and DONE; captured operands SHALL NOT change mid-operation.
REQ-013 In SHIFT with counter>0, each cycle the block SHALL apply exactly one 1-bit shift per the captured op and decrement the counter by 1.
REQ-014 For SLL the shift SHALL be reg<={reg[30:0],1'b0}.
REQ-015 For SRA the shift SHALL be reg<={reg[31],reg[31:1]}, with sign bit replicated.
REQ-016 For SRL the shift SHALL be reg<={1'b0,reg[31:1]}.
REQ-017 For ROR the shift SHALL be reg<={reg[0],reg[31:1]}.
REQ-018 In SHIFT with counter==0, the block SHALL perform no shift and transition to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency: start accepted in cycle N SHALL yield done=1 in cycle N+2+shamt (shamt=0 gives N+2; shamt=31 gives N+33).
REQ-021 busy SHALL be 1 from cycle N+1 through the DONE cycle inclusive.
REQ-022 result SHALL continuously reflect the working register.
REQ-023 result SHALL hold its final value in IDLE until the next accepted start.
REQ-024 start high in the DONE cycle SHALL be ignored; start held high continuously SHALL be accepted on the first IDLE cycle after DONE (back-to-back spacing shamt+3 cycles).
REQ-025 The counter SHALL never underflow or wrap; shamt width limits shifts to 31.
REQ-026 Operands and result SHALL be treated as raw 32-bit patterns with no overflow or exception flag.

Reset
REQ-027 reset=1 at a rising edge SHALL force state=IDLE, working register=0, counter=0, op register=00; thus result=0, busy=0, done=0 in the following cycle.
REQ-028 reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-029 An operation SHALL be startable in the first cycle after reset deasserts.

Verification
REQ-030 The bench SHALL check: SRA, data_in=0x80000000, shamt=4, start at N -> result=0xF8000000, done=1 at N+6 only.
REQ-031 The bench SHALL check: SLL, data_in=0x00000001, shamt=31 -> result=0x80000000, done at N+33, busy high N+1..N+33.
REQ-032 The bench SHALL check: shamt=0, op=SRL, data_in=0xDEADBEEF -> result=0xDEADBEEF, done at N+2.
REQ-033 The bench SHALL check: ROR, data_in=0x0000000F, shamt=4 -> result=0xF0000000; SRL of 0x80000000 by 4 -> 0x08000000.
REQ-034 The bench SHALL check: start pulsed with new data_in during SHIFT -> ignored, original result unchanged, single done pulse.
REQ-035 The bench SHALL check: reset asserted mid-SHIFT (SRA, shamt=20, reset at N+5) -> next cycle result=0, busy=0, no done; new start at following cycle completes correctly.
